// File: rtl/stopwatch_bcd_counter.sv
// Parametrised BCD stopwatch/timer counter with divider, up/down, preload and sticky flags.
// Optional lap-capture register is compiled in when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd_counter #(
    parameter int unsigned CLK_FREQ    = 100000000,
    parameter int unsigned TICK_HZ     = 1,
    parameter int unsigned NUM_DIGITS  = 4,
    parameter bit          SEXAGESIMAL = 1'b1
) (
    input  logic                    clk,
    input  logic                    init_regs,
    input  logic                    count_enabled,
    input  logic                    count_down,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    input  logic                    lap,
    output logic [4*NUM_DIGITS-1:0] time_reading,
    output logic                    tick,
    output logic                    rollover,
    output logic                    expired,
    output logic [4*NUM_DIGITS-1:0] lap_reading,
    output logic                    lap_valid
);

    localparam int unsigned DIV   = CLK_FREQ / TICK_HZ;
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned W     = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [W-1:0]     up_value;
    logic [W-1:0]     down_value;
    logic [W-1:0]     load_clean;
    logic             up_wrap;
    logic             at_zero;
    logic             down_zero;

    function automatic logic [3:0] digit_max(input int unsigned idx);
        return (SEXAGESIMAL && (idx % 2 == 1)) ? 4'd5 : 4'd9;
    endfunction

    // Ripple carry/borrow evaluated across all digits so the whole reading updates on one edge.
    always_comb begin : next_value
        logic [3:0] d;
        logic       carry;
        logic       borrow;
        d          = '0;
        carry      = 1'b1;
        borrow     = 1'b1;
        up_value   = time_reading;
        down_value = time_reading;
        load_clean = load_value;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            d = time_reading[4*i +: 4];
            if (carry) begin
                if (d >= digit_max(i)) begin
                    up_value[4*i +: 4] = '0;
                end else begin
                    up_value[4*i +: 4] = d + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (d == 4'd0) begin
                    down_value[4*i +: 4] = digit_max(i);
                end else begin
                    down_value[4*i +: 4] = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_value[4*i +: 4] > digit_max(i)) begin
                load_clean[4*i +: 4] = '0;
            end
        end
        up_wrap   = carry;
        at_zero   = (time_reading == '0);
        down_zero = (down_value == '0);
    end

    always_ff @(posedge clk) begin
        if (init_regs) begin
            div_cnt      <= '0;
            time_reading <= '0;
            tick         <= 1'b0;
            rollover     <= 1'b0;
            expired      <= 1'b0;
        end else begin
            tick <= 1'b0;
            if (load) begin
                time_reading <= load_clean;
                div_cnt      <= '0;
                rollover     <= 1'b0;
                expired      <= 1'b0;
            end else if (count_enabled) begin
                if (div_cnt == DIV_LAST) begin
                    div_cnt <= '0;
                    if (count_down) begin
                        // Down-counting saturates at zero: no tick, flag held high.
                        if (at_zero) begin
                            expired <= 1'b1;
                        end else begin
                            time_reading <= down_value;
                            tick         <= 1'b1;
                            if (down_zero) expired <= 1'b1;
                        end
                    end else begin
                        time_reading <= up_value;
                        tick         <= 1'b1;
                        if (up_wrap) rollover <= 1'b1;
                    end
                end else begin
                    div_cnt <= div_cnt + DIV_W'(1);
                end
            end
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Captures the reading from before this edge, so a same-edge tick or load is not seen.
    always_ff @(posedge clk) begin
        if (init_regs) begin
            lap_reading <= '0;
            lap_valid   <= 1'b0;
        end else if (lap) begin
            lap_reading <= time_reading;
            lap_valid   <= 1'b1;
        end
    end
`else
    logic unused_lap;
    assign unused_lap  = lap;
    assign lap_reading = '0;
    assign lap_valid   = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_counter.sv
// Self-checking bench for stopwatch_bcd_counter (DIV=10, 4 digits, sexagesimal).
// Table-driven vectors through an expectation queue, plus a tick-spacing sequence.
module tb_stopwatch_bcd_counter;

    logic        clk = 1'b0;
    logic        init_regs;
    logic        count_enabled;
    logic        count_down;
    logic        load;
    logic [15:0] load_value;
    logic        lap;
    logic [15:0] time_reading;
    logic        tick;
    logic        rollover;
    logic        expired;
    logic [15:0] lap_reading;
    logic        lap_valid;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_ON = 1'b1;
`else
    localparam bit LAP_ON = 1'b0;
`endif

    always #5 clk = ~clk;

    stopwatch_bcd_counter #(
        .CLK_FREQ   (10),
        .TICK_HZ    (1),
        .NUM_DIGITS (4),
        .SEXAGESIMAL(1'b1)
    ) dut (
        .clk          (clk),
        .init_regs    (init_regs),
        .count_enabled(count_enabled),
        .count_down   (count_down),
        .load         (load),
        .load_value   (load_value),
        .lap          (lap),
        .time_reading (time_reading),
        .tick         (tick),
        .rollover     (rollover),
        .expired      (expired),
        .lap_reading  (lap_reading),
        .lap_valid    (lap_valid)
    );

    typedef struct {
        bit [79:0]   nm;
        bit          init;
        bit          en;
        bit          dn;
        bit          ld;
        logic [15:0] lv;
        bit          lp;
        int          cyc;
        logic [15:0] e_time;
        bit          e_tick;
        bit          e_roll;
        bit          e_exp;
        logic [15:0] e_lap;
        bit          e_lapv;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   gap_q[$];

    function automatic vec_t mkv(input bit [79:0] nm, input bit init, input bit en, input bit dn,
                                 input bit ld, input logic [15:0] lv, input bit lp, input int cyc,
                                 input logic [15:0] et, input bit etk, input bit er, input bit ee,
                                 input logic [15:0] el, input bit elv);
        vec_t v;
        v.nm = nm; v.init = init; v.en = en; v.dn = dn; v.ld = ld; v.lv = lv; v.lp = lp;
        v.cyc = cyc; v.e_time = et; v.e_tick = etk; v.e_roll = er; v.e_exp = ee;
        v.e_lap = el; v.e_lapv = elv;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t        v;
        vec_t        e;
        logic [15:0] l9;
        logic [15:0] l1;
        int          cnt;
        int          want;

        init_regs = 1'b1; count_enabled = 1'b0; count_down = 1'b0;
        load = 1'b0; load_value = '0; lap = 1'b0;

        l9 = LAP_ON ? 16'h0009 : 16'h0000;
        l1 = LAP_ON ? 16'h0001 : 16'h0000;

        //             name          ini en dn ld lv       lp cyc  time     tk ro ex lap     lv
        vecs.push_back(mkv("reset",     1, 0, 0, 0, 16'h0000, 0, 2,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("up_pre",    0, 1, 0, 0, 16'h0000, 0, 9,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("up_t1",     0, 1, 0, 0, 16'h0000, 0, 1,   16'h0001, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("tick_1cyc", 0, 1, 0, 0, 16'h0000, 0, 1,   16'h0001, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("up_10",     0, 1, 0, 0, 16'h0000, 0, 89,  16'h0010, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("up_60",     0, 1, 0, 0, 16'h0000, 0, 500, 16'h0100, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("ld5959",    0, 1, 0, 1, 16'h5959, 0, 1,   16'h5959, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("ld5959_w",  0, 1, 0, 0, 16'h0000, 0, 9,   16'h5959, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("rollover",  0, 1, 0, 0, 16'h0000, 0, 1,   16'h0000, 1, 1, 0, 16'h0, 0));
        vecs.push_back(mkv("roll_stky", 0, 1, 0, 0, 16'h0000, 0, 10,  16'h0001, 1, 1, 0, 16'h0, 0));
        vecs.push_back(mkv("ld_0A07",   0, 0, 0, 1, 16'h0A07, 0, 1,   16'h0007, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("ld_0100",   0, 1, 1, 1, 16'h0100, 0, 1,   16'h0100, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("borrow59",  0, 1, 1, 0, 16'h0000, 0, 10,  16'h0059, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("ld_0002",   0, 1, 1, 1, 16'h0002, 0, 1,   16'h0002, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("dn_0001",   0, 1, 1, 0, 16'h0000, 0, 10,  16'h0001, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("dn_expire", 0, 1, 1, 0, 16'h0000, 0, 10,  16'h0000, 1, 0, 1, 16'h0, 0));
        vecs.push_back(mkv("dn_hold",   0, 1, 1, 0, 16'h0000, 0, 30,  16'h0000, 0, 0, 1, 16'h0, 0));
        vecs.push_back(mkv("ld_clrexp", 0, 1, 0, 1, 16'h0000, 0, 1,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("pause_a",   0, 1, 0, 0, 16'h0000, 0, 5,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("pause_off", 0, 0, 0, 0, 16'h0000, 0, 100, 16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("pause_b",   0, 1, 0, 0, 16'h0000, 0, 4,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("pause_tk",  0, 1, 0, 0, 16'h0000, 0, 1,   16'h0001, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("ld_0008",   0, 1, 0, 1, 16'h0008, 0, 1,   16'h0008, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("to_0009",   0, 1, 0, 0, 16'h0000, 0, 10,  16'h0009, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("lap_pre",   0, 1, 0, 0, 16'h0000, 0, 9,   16'h0009, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("lap_fire",  0, 1, 0, 0, 16'h0000, 1, 1,   16'h0010, 1, 0, 0, l9,    LAP_ON));
        vecs.push_back(mkv("lap_keep",  0, 1, 0, 0, 16'h0000, 0, 9,   16'h0010, 0, 0, 0, l9,    LAP_ON));
        vecs.push_back(mkv("init_all",  1, 1, 0, 1, 16'h1234, 1, 1,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("post_init", 0, 1, 0, 0, 16'h0000, 0, 9,   16'h0000, 0, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("post_tk",   0, 1, 0, 0, 16'h0000, 0, 1,   16'h0001, 1, 0, 0, 16'h0, 0));
        vecs.push_back(mkv("lap_load",  0, 0, 0, 1, 16'h0042, 1, 1,   16'h0042, 0, 0, 0, l1,    LAP_ON));

        for (int k = 0; k < vecs.size(); k++) begin
            v = vecs[k];
            init_regs = v.init; count_enabled = v.en; count_down = v.dn;
            load = v.ld; load_value = v.lv; lap = v.lp;
            exp_q.push_back(v);
            repeat (v.cyc) step();
            e = exp_q.pop_front();
            n_tests++;
            if (time_reading !== e.e_time || tick !== e.e_tick || rollover !== e.e_roll ||
                expired !== e.e_exp || lap_reading !== e.e_lap || lap_valid !== e.e_lapv) begin
                n_fail++;
                $display("FAIL %0s: got time=%h tick=%b roll=%b exp=%b lap=%h lapv=%b, want time=%h tick=%b roll=%b exp=%b lap=%h lapv=%b",
                         e.nm, time_reading, tick, rollover, expired, lap_reading, lap_valid,
                         e.e_time, e.e_tick, e.e_roll, e.e_exp, e.e_lap, e.e_lapv);
            end
        end

        // Tick spacing: from reset with enable held, every gap is exactly DIV cycles.
        init_regs = 1'b1; count_enabled = 1'b0; load = 1'b0; lap = 1'b0; count_down = 1'b0;
        step();
        init_regs = 1'b0; count_enabled = 1'b1;
        for (int t = 0; t < 4; t++) begin
            gap_q.push_back(10);
            cnt = 0;
            do begin
                step();
                cnt++;
            end while (tick !== 1'b1 && cnt < 20);
            want = gap_q.pop_front();
            n_tests++;
            if (cnt != want) begin
                n_fail++;
                $display("FAIL tick_gap%0d: got %0d cycles, want %0d", t, cnt, want);
            end
        end
        n_tests++;
        if (time_reading !== 16'h0004) begin
            n_fail++;
            $display("FAIL gap_reading: got %h, want 0004", time_reading);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_bcd_counter.md
# stopwatch_bcd_counter

Parametrised successor to the lab-1 two-digit seconds counter. It counts a configurable number of BCD digits at a configurable tick rate, with optional minutes-style (mod-6) tens digits, up/down direction, parallel preload, sticky rollover/expiry flags and an optional lap-capture register. It sits between the debounced button/control FSM and the seven-segment display driver on the BASYS3 stopwatch/timer.

## Interface
Parameters:
- CLK_FREQ, 100000000, input clock frequency in Hz.
- TICK_HZ, 1, count rate in Hz. DIV = CLK_FREQ/TICK_HZ must be an integer ≥ 2.
- NUM_DIGITS, 4, number of BCD digits, 1..8. Digit 0 is the least significant.
- SEXAGESIMAL, 1, selects the per-digit modulus.
  - 1: odd-indexed digits wrap mod 6; even-indexed digits wrap mod 10.
  - 0: all digits wrap mod 10.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock.
- init_regs  in  1  synchronous active-high reset. Clears every register.
- count_enabled  in  1  advances the divider while high. Low means pause (state held).
- count_down  in  1  0 = count up, 1 = count down. Sampled on each tick edge.
- load  in  1  one-cycle request to load load_value.
- load_value  in  4*NUM_DIGITS  BCD preload value.
- lap  in  1  request to capture the current reading.
- time_reading  out  4*NUM_DIGITS  registered BCD reading, {digit N-1 … digit 0}.
- tick  out  1  one-cycle pulse, high in the cycle a new counted value is first visible.
- rollover  out  1  sticky flag: an up-count wrapped from maximum to zero.
- expired  out  1  sticky flag: a down-count reached zero.
- lap_reading  out  4*NUM_DIGITS  captured reading.
- lap_valid  out  1  set once a lap capture has occurred.

## Operation
- Reset state (after init_regs): all outputs are 0, and the divider count is 0.
- Priority on each edge: init_regs > load > counting.
- Divider:
  - div_cnt runs 0..DIV-1 and only advances while count_enabled is high.
  - The divider fires when count_enabled=1 and div_cnt=DIV-1. On that edge div_cnt returns to 0.
  - A pause holds div_cnt; it does not clear it.
- Up tick: digit 0 increments. Each digit that wraps to 0 carries into the next digit (ripple, same edge). If every digit wraps, the reading becomes all-zero and rollover is set.
- Down tick:
  - Digit 0 decrements, borrowing from the next digit. A digit borrowing from 0 becomes modulus-1.
  - If the resulting value is all-zero, expired is set.
  - If the reading is already all-zero, it holds, no tick is pulsed, and expired stays (or becomes) 1. Down-counting never wraps.
- Load:
  - time_reading is set to load_value, div_cnt is cleared, and rollover and expired are cleared.
  - Any load digit ≥ its modulus is loaded as 0.
  - No tick is pulsed.
- count_down may change at any time. The divider phase is unaffected; the value on the firing edge decides the direction.
- Lap (when compiled in): on an edge with lap=1, lap_reading ← the time_reading value present before that edge (the pre-tick value if a tick fires on the same edge), and lap_valid ← 1.
  - lap is ignored on edges where init_regs is high.
  - lap combined with load captures the old reading.
- rollover and expired are cleared only by init_regs or load.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Tick latency: tick rises with the new time_reading, one cycle after the cycle in which div_cnt=DIV-1 and count_enabled=1. It is high for exactly 1 cycle.
- Tick spacing: with count_enabled continuously high, ticks occur every DIV cycles. The first tick after reset or load arrives DIV enabled cycles later.
- Load, init_regs and lap take effect on the next edge (latency 1).
- Flags change on the same edge as the reading that caused them.
- A reset asserted mid-interval discards the partial divider count.

## Configuration
- STOPWATCH_LAP_EN:
  - Defined: the lap-capture register and lap_valid are implemented as described above.
  - Undefined: lap is ignored, lap_reading is tied to 0 and lap_valid is tied to 0.
  - Port list is identical in both builds.

## Test plan
Benches use CLK_FREQ=10, TICK_HZ=1 (DIV=10), NUM_DIGITS=4, SEXAGESIMAL=1.
- Up count from reset, count_enabled=1: after 10 ticks time_reading=16'h0010; after 60 ticks 16'h0100; tick pulses exactly every 10 cycles.
- Load 16'h5959, then count up: one tick later time_reading=16'h0000, rollover=1, tick=1. Load 16'h0A07 → time_reading=16'h0007.
- Load 16'h0002, count_down=1: ticks give 16'h0001, then 16'h0000 with expired=1 on that edge. After 30 further cycles the reading is still 16'h0000, no tick pulses and expired=1.
- Pause: count_enabled=1 for 5 cycles, 0 for 100 cycles, then 1 again: the next tick arrives on the 10th enabled cycle and the reading is 16'h0001.
- Lap asserted on the cycle the divider fires at 16'h0009: time_reading=16'h0010, lap_reading=16'h0009, lap_valid=1. With STOPWATCH_LAP_EN undefined: lap_reading=0, lap_valid=0.
- init_regs, load=1 (16'h1234) and a divider firing, all on the same cycle: next cycle all outputs are 0, and the next tick occurs 10 cycles later.
